// File: rtl/slot_sequencer_ctrl_if.sv
// Control/status bundle between the lab-board switches and the slot sequencer.
// The master side drives the switch inputs and watches the display path; the
// sequencer itself connects through the slave side.
interface slot_sequencer_ctrl_if #(
  parameter int NSLOT   = 8,
  parameter int CW      = 3,
  parameter int DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic               step;
  logic               mode;
  logic [NSLOT-1:0]   slot_mask;
  logic [DWELL_W-1:0] dwell;
  logic [CW-1:0]      counter_out;
  logic [NSLOT-1:0]   decoder_out;
  logic               busy;
  logic               wrap;

  modport master (
    output start, stop, step, mode, slot_mask, dwell,
    input  counter_out, decoder_out, busy, wrap
  );

  modport slave (
    input  start, stop, step, mode, slot_mask, dwell,
    output counter_out, decoder_out, busy, wrap
  );
endinterface

// File: rtl/slot_sequencer_ctrl.sv
// Time-slot scheduler for the counter/one-hot decoder display path.
// Walks the enabled slots of slot_mask in ascending order with wrap-around,
// holding each slot for dwell+1 cycles (RUN) or until a step pulse (STEP).
// Every output is registered, so a decision taken on one edge shows up in the
// following cycle. CW must equal log2(NSLOT): the slot arithmetic relies on
// the natural CW-bit rollover to implement the modulo-NSLOT wrap.
module slot_sequencer_ctrl #(
  parameter int NSLOT   = 8,
  parameter int CW      = 3,
  parameter int DWELL_W = 4
) (
  input  logic                 clockpulse,
  input  logic                 clear,
  slot_sequencer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      counter_q, counter_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [NSLOT-1:0]   decoder_q, decoder_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;

  // Mask scan results
  logic               mask_any;
  logic [CW-1:0]      first_slot;
  logic [CW-1:0]      next_slot;
  logic [CW-1:0]      scan_idx;
  logic               scan_found;
  logic               advance;

  assign mask_any = |bus.slot_mask;

  // Find the lowest enabled slot (used on start) and the next enabled slot
  // after the current one, scanning upward and ending on the current slot.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves a variable unassigned would infer a latch.
    first_slot = '0;
    next_slot  = counter_q;
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (bus.slot_mask[i]) begin
        first_slot = CW'(i);
      end
    end
    for (int i = 1; i <= NSLOT; i++) begin
      scan_idx = counter_q + CW'(i);
      if (!scan_found && bus.slot_mask[scan_idx]) begin
        next_slot  = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  // Advance request: dwell expiry in RUN, a step pulse in STEP.
  always_comb begin
    advance = 1'b0;
    case (state_q)
      S_RUN:   advance = (dwell_cnt_q == bus.dwell);
      S_STEP:  advance = bus.step;
      default: advance = 1'b0;
    endcase
  end

  // Next-state and next-output decode; stop outranks start, step and dwell.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    dwell_cnt_d = dwell_cnt_q;
    wrap_d      = 1'b0;

    if (bus.stop) begin
      state_d     = S_IDLE;
      counter_d   = '0;
      dwell_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A start with no enabled slot is simply ignored.
          if (bus.start && mask_any) begin
            state_d     = bus.mode ? S_STEP : S_RUN;
            counter_d   = first_slot;
            dwell_cnt_d = '0;
          end
        end

        S_RUN, S_STEP: begin
          if (advance) begin
            dwell_cnt_d = '0;
            if (!mask_any) begin
              // Every slot disabled: fall back to IDLE without a wrap pulse.
              state_d   = S_IDLE;
              counter_d = '0;
            end else begin
              counter_d = next_slot;
              wrap_d    = (next_slot <= counter_q);
            end
          end else if (state_q == S_RUN) begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end

        default: begin
          state_d     = S_IDLE;
          counter_d   = '0;
          dwell_cnt_d = '0;
        end
      endcase
    end

    // Registered display outputs derive from the next state so that the
    // decoder always tracks the counter in the same cycle.
    busy_d    = (state_d != S_IDLE);
    decoder_d = busy_d ? (NSLOT'(1) << counter_d) : '0;
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clockpulse) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (clear) begin
      state_q     <= S_IDLE;
      counter_q   <= '0;
      dwell_cnt_q <= '0;
      decoder_q   <= '0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      dwell_cnt_q <= dwell_cnt_d;
      decoder_q   <= decoder_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.counter_out = counter_q;
  assign bus.decoder_out = decoder_q;
  assign bus.busy        = busy_q;
  assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_slot_sequencer_ctrl.sv
// Self-checking bench for slot_sequencer_ctrl: directed scenarios with fixed
// expectations plus a randomized run, all cross-checked every cycle against a
// behavioural slot-scheduler model.
module tb_slot_sequencer_ctrl;
  localparam int NSLOT   = 8;
  localparam int CW      = 3;
  localparam int DWELL_W = 4;

  logic clockpulse = 1'b0;
  logic clear      = 1'b0;

  slot_sequencer_ctrl_if #(.NSLOT(NSLOT), .CW(CW), .DWELL_W(DWELL_W)) bus ();

  slot_sequencer_ctrl #(.NSLOT(NSLOT), .CW(CW), .DWELL_W(DWELL_W)) dut (
    .clockpulse (clockpulse),
    .clear      (clear),
    .bus        (bus)
  );

  always #5 clockpulse = ~clockpulse;

  int checks = 0;
  int errors = 0;

  // Behavioural model: is a sweep active, which mode, current slot, age of slot.
  bit m_busy   = 1'b0;
  bit m_single = 1'b0;
  bit m_wrap   = 1'b0;
  int m_slot   = 0;
  int m_age    = 0;

  function automatic int lowest_enabled(input logic [NSLOT-1:0] mask);
    for (int k = 0; k < NSLOT; k++) if (mask[k]) return k;
    return -1;
  endfunction

  function automatic int following_enabled(input int cur, input logic [NSLOT-1:0] mask);
    for (int k = 1; k <= NSLOT; k++) begin
      int idx;
      idx = (cur + k) % NSLOT;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Apply the scheduling rules for one rising edge using the current inputs.
  task automatic model_edge();
    bit do_adv;
    m_wrap = 1'b0;
    if (clear) begin
      m_busy = 1'b0; m_slot = 0; m_age = 0;
    end else if (bus.stop) begin
      m_busy = 1'b0; m_slot = 0; m_age = 0;
    end else if (!m_busy) begin
      if (bus.start && bus.slot_mask != '0) begin
        m_busy   = 1'b1;
        m_single = bus.mode;
        m_slot   = lowest_enabled(bus.slot_mask);
        m_age    = 0;
      end
    end else begin
      // A slot lives for dwell+1 cycles in continuous mode.
      do_adv = m_single ? bus.step : (m_age + 1 == int'(bus.dwell) + 1);
      if (do_adv) begin
        if (bus.slot_mask == '0) begin
          m_busy = 1'b0; m_slot = 0;
        end else begin
          int nxt;
          nxt    = following_enabled(m_slot, bus.slot_mask);
          m_wrap = (nxt <= m_slot);
          m_slot = nxt;
        end
        m_age = 0;
      end else if (!m_single) begin
        m_age++;
      end
    end
  endtask

  // One clock cycle: edge, model update, then compare away from the edge.
  task automatic tick();
    logic [NSLOT-1:0] exp_dec;
    logic [NSLOT-1:0] inv_dec;
    @(posedge clockpulse);
    model_edge();
    #1;
    exp_dec = m_busy ? (NSLOT'(1) << m_slot) : '0;
    checks++;
    if (bus.counter_out !== CW'(m_slot)) begin
      errors++;
      $display("FAIL model_counter t=%0t got %0d want %0d", $time, bus.counter_out, m_slot);
    end
    checks++;
    if (bus.decoder_out !== exp_dec) begin
      errors++;
      $display("FAIL model_decoder t=%0t got %b want %b", $time, bus.decoder_out, exp_dec);
    end
    checks++;
    if (bus.busy !== m_busy) begin
      errors++;
      $display("FAIL model_busy t=%0t got %b want %b", $time, bus.busy, m_busy);
    end
    checks++;
    if (bus.wrap !== m_wrap) begin
      errors++;
      $display("FAIL model_wrap t=%0t got %b want %b", $time, bus.wrap, m_wrap);
    end
    inv_dec = bus.busy ? (NSLOT'(1) << bus.counter_out) : '0;
    checks++;
    if (bus.decoder_out !== inv_dec) begin
      errors++;
      $display("FAIL invariant_decoder t=%0t got %b want %b", $time, bus.decoder_out, inv_dec);
    end
  endtask

  task automatic drive_quiet();
    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.mode = 1'b0;
  endtask

  task automatic go_idle();
    drive_quiet();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    drive_quiet();
    bus.slot_mask = 8'hFF;
    bus.dwell     = '0;
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    checks++;
    if (bus.counter_out !== 3'd0 || bus.decoder_out !== 8'h00 || bus.busy !== 1'b0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got cnt=%0d dec=%h busy=%b wrap=%b want 0/00/0/0",
               bus.counter_out, bus.decoder_out, bus.busy, bus.wrap);
    end
  endtask

  task automatic test_full_sweep();
    go_idle();
    bus.slot_mask = 8'hFF; bus.dwell = 4'd0; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.counter_out !== 3'd0 || bus.busy !== 1'b1 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL sweep_start got cnt=%0d busy=%b wrap=%b want 0/1/0", bus.counter_out, bus.busy, bus.wrap);
    end
    for (int i = 1; i <= 8; i++) begin
      int exp;
      logic [7:0] exp_dec;
      tick();
      exp     = i % 8;
      exp_dec = 8'(1) << exp;
      checks++;
      if (bus.counter_out !== 3'(exp) || bus.decoder_out !== exp_dec || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL sweep_slot step %0d got cnt=%0d dec=%h busy=%b want %0d/%h/1",
                 i, bus.counter_out, bus.decoder_out, bus.busy, exp, exp_dec);
      end
      checks++;
      if (bus.wrap !== (i == 8)) begin
        errors++;
        $display("FAIL sweep_wrap step %0d got %b want %b", i, bus.wrap, (i == 8));
      end
    end
  endtask

  task automatic test_masked_dwell();
    int seq [3] = '{2, 5, 7};
    go_idle();
    bus.slot_mask = 8'b1010_0100; bus.dwell = 4'd2; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.counter_out !== 3'd2) begin
      errors++;
      $display("FAIL masked_first got %0d want 2", bus.counter_out);
    end
    for (int c = 1; c <= 12; c++) begin
      int exp;
      bit exp_wrap;
      tick();
      exp      = seq[(c / 3) % 3];
      exp_wrap = (c % 3 == 0) && ((c / 3) % 3 == 0);
      checks++;
      if (bus.counter_out !== 3'(exp) || bus.wrap !== exp_wrap) begin
        errors++;
        $display("FAIL masked_slot cycle %0d got cnt=%0d wrap=%b want %0d/%b",
                 c, bus.counter_out, bus.wrap, exp, exp_wrap);
      end
    end
    go_idle();
    bus.slot_mask = 8'h10; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (bus.counter_out !== 3'd4 || bus.wrap !== (c % 3 == 0)) begin
        errors++;
        $display("FAIL single_slot cycle %0d got cnt=%0d wrap=%b want 4/%b",
                 c, bus.counter_out, bus.wrap, (c % 3 == 0));
      end
    end
  endtask

  task automatic test_single_step();
    go_idle();
    bus.slot_mask = 8'hFF; bus.dwell = 4'd0;
    bus.step = 1'b1;
    tick();
    tick();
    bus.step = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.counter_out !== 3'd0) begin
      errors++;
      $display("FAIL step_in_idle got busy=%b cnt=%0d want 0/0", bus.busy, bus.counter_out);
    end
    bus.mode = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.mode = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.counter_out !== 3'd0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL step_hold cycle %0d got cnt=%0d busy=%b want 0/1", c, bus.counter_out, bus.busy);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      checks++;
      if (bus.counter_out !== 3'(k)) begin
        errors++;
        $display("FAIL step_advance pulse %0d got %0d want %0d", k, bus.counter_out, k);
      end
      tick();
      tick();
      checks++;
      if (bus.counter_out !== 3'(k)) begin
        errors++;
        $display("FAIL step_settle pulse %0d got %0d want %0d", k, bus.counter_out, k);
      end
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.counter_out !== 3'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy got cnt=%0d busy=%b want 3/1", bus.counter_out, bus.busy);
    end
  endtask

  task automatic test_stop_priority();
    go_idle();
    bus.slot_mask = 8'hFF; bus.dwell = 4'd0; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.counter_out !== 3'd5) begin
      errors++;
      $display("FAIL stop_setup got %0d want 5", bus.counter_out);
    end
    bus.stop = 1'b1; bus.start = 1'b1;
    tick();
    bus.stop = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.counter_out !== 3'd0 || bus.decoder_out !== 8'h00 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL stop_over_start got busy=%b cnt=%0d dec=%h wrap=%b want 0/0/00/0",
               bus.busy, bus.counter_out, bus.decoder_out, bus.wrap);
    end
    bus.slot_mask = 8'h00; bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.decoder_out !== 8'h00) begin
      errors++;
      $display("FAIL start_mask_zero got busy=%b dec=%h want 0/00", bus.busy, bus.decoder_out);
    end
  endtask

  task automatic test_mask_cleared();
    go_idle();
    bus.slot_mask = 8'hFF; bus.dwell = 4'd3; bus.mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    checks++;
    if (bus.counter_out !== 3'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mask_clear_setup got cnt=%0d busy=%b want 3/1", bus.counter_out, bus.busy);
    end
    bus.slot_mask = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.counter_out !== 3'd3 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL mask_clear_hold cycle %0d got cnt=%0d busy=%b want 3/1", c, bus.counter_out, bus.busy);
      end
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.decoder_out !== 8'h00 || bus.wrap !== 1'b0 || bus.counter_out !== 3'd0) begin
      errors++;
      $display("FAIL mask_clear_idle got busy=%b dec=%h wrap=%b cnt=%0d want 0/00/0/0",
               bus.busy, bus.decoder_out, bus.wrap, bus.counter_out);
    end
  endtask

  task automatic test_clear_mid();
    go_idle();
    bus.slot_mask = 8'hFF; bus.dwell = 4'd0; bus.mode = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.step = 1'b1;
    repeat (6) tick();
    checks++;
    if (bus.counter_out !== 3'd6) begin
      errors++;
      $display("FAIL clear_setup got %0d want 6", bus.counter_out);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; bus.step = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.counter_out !== 3'd0 || bus.decoder_out !== 8'h00 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid got busy=%b cnt=%0d dec=%h wrap=%b want 0/0/00/0",
               bus.busy, bus.counter_out, bus.decoder_out, bus.wrap);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.step = 1'b1;
    tick();
    tick();
    bus.step = 1'b0;
    clear = 1'b1;
    #3;
    checks++;
    if (bus.counter_out !== 3'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_between_edges got cnt=%0d busy=%b want 2/1", bus.counter_out, bus.busy);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (bus.counter_out !== 3'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_glitch_after got cnt=%0d busy=%b want 2/1", bus.counter_out, bus.busy);
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int n = 0; n < 2000; n++) begin
      clear    = ($urandom_range(0, 199) == 0);
      bus.stop = ($urandom_range(0, 99) < 3);
      bus.start = ($urandom_range(0, 99) < 15);
      bus.step = ($urandom_range(0, 99) < 30);
      bus.mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 10) begin
        case ($urandom_range(0, 3))
          0:       bus.slot_mask = 8'h00;
          1:       bus.slot_mask = 8'(1) << $urandom_range(0, 7);
          default: bus.slot_mask = 8'($urandom);
        endcase
      end
      if (!m_busy) bus.dwell = 4'($urandom_range(0, 3));
      tick();
    end
    clear = 1'b0;
    drive_quiet();
  endtask

  initial begin
    drive_quiet();
    bus.slot_mask = '0;
    bus.dwell     = '0;
    test_reset();
    test_full_sweep();
    test_masked_dwell();
    test_single_step();
    test_stop_priority();
    test_mask_cleared();
    test_clear_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
